// File: rtl/alu_issue_stage.sv
// ID/EX issue stage in front of the ALU. It accepts decoded micro-ops over a
// valid/ready handshake, picks operands (x0, writeback-forwarded, register or
// immediate) and decodes the op into one-hot ALU selects. A two-entry skid
// buffer (main + skid) keeps in_ready a pure flop output. Buffered operands
// snoop the writeback port so they stay coherent while stalled.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [RADDR-1:0] in_rs1_addr,
  input  logic [RADDR-1:0] in_rs2_addr,
  input  logic [WIDTH-1:0] in_rs1_data,
  input  logic [WIDTH-1:0] in_rs2_data,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic [RADDR-1:0] in_rd_addr,
  input  logic             in_rd_we,
  input  logic             wb_we,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic             alu_sel_add,
  output logic             alu_sel_sub,
  output logic             alu_sel_nop,
  output logic             alu_sel_pass1,
  output logic             alu_sel_pass2,
  output logic [RADDR-1:0] out_rd_addr,
  output logic             out_rd_we,
  output logic             out_illegal
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  // One-hot select vector order: {pass2, pass1, sub, add, nop}
  localparam logic [4:0] SEL_NOP   = 5'b00001;
  localparam logic [4:0] SEL_ADD   = 5'b00010;
  localparam logic [4:0] SEL_SUB   = 5'b00100;
  localparam logic [4:0] SEL_PASS1 = 5'b01000;
  localparam logic [4:0] SEL_PASS2 = 5'b10000;

  // Source addresses and use_imm are kept so held entries can snoop writeback.
  typedef struct packed {
    logic [RADDR-1:0] rs1;
    logic [RADDR-1:0] rs2;
    logic             use_imm;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [RADDR-1:0] rd_addr;
    logic             rd_we;
    logic [4:0]       sel;
    logic             illegal;
  } entry_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_in_ready;
  entry_t r_main;
  entry_t r_skid;
  entry_t w_cap;
  entry_t w_main_snp;
  entry_t w_skid_snp;
  logic   w_in_xfer;
  logic   w_out_xfer;
  logic   w_load_main_in;
  logic   w_load_main_skid;
  logic   w_hold_main;
  logic   w_load_skid;
  logic   w_hold_skid;

  // x0 reads as zero; a same-cycle writeback to the source wins over the RF.
  function automatic logic [WIDTH-1:0] fwd_operand(
    input logic [RADDR-1:0] addr,
    input logic [WIDTH-1:0] rf_data,
    input logic             we,
    input logic [RADDR-1:0] rd,
    input logic [WIDTH-1:0] data
  );
    if (addr == '0)             return '0;
    else if (we && rd == addr)  return data;
    else                        return rf_data;
  endfunction

  // Refresh register-sourced operands of a held entry; immediates never snoop.
  function automatic entry_t snoop_entry(
    input entry_t           e,
    input logic             we,
    input logic [RADDR-1:0] rd,
    input logic [WIDTH-1:0] data
  );
    entry_t r;
    r = e;
    if (we && rd != '0) begin
      if (e.rs1 == rd)                 r.a = data;
      if (!e.use_imm && e.rs2 == rd)   r.b = data;
    end
    return r;
  endfunction

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = (r_state != S_EMPTY) && out_ready;

  // Build the entry for the op currently on the input port (operands + decode).
  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    w_cap         = '0;
    w_cap.rs1     = in_rs1_addr;
    w_cap.rs2     = in_rs2_addr;
    w_cap.use_imm = in_use_imm;
    w_cap.rd_addr = in_rd_addr;
    w_cap.a       = fwd_operand(in_rs1_addr, in_rs1_data, wb_we, wb_rd, wb_data);
    w_cap.b       = in_use_imm ? in_imm
                  : fwd_operand(in_rs2_addr, in_rs2_data, wb_we, wb_rd, wb_data);
    w_cap.sel     = SEL_NOP;
    case (in_op)
      3'd0: w_cap.sel = SEL_NOP;
      3'd1: begin w_cap.sel = SEL_ADD;   w_cap.rd_we = in_rd_we; end
      3'd2: begin w_cap.sel = SEL_SUB;   w_cap.rd_we = in_rd_we; end
      3'd3: begin w_cap.sel = SEL_PASS1; w_cap.rd_we = in_rd_we; end
      3'd4: begin w_cap.sel = SEL_PASS2; w_cap.rd_we = in_rd_we; end
      default: w_cap.illegal = 1'b1;
    endcase
  end

  // Snooped views of both stored entries for this cycle's writeback.
  always_comb begin
    w_main_snp = snoop_entry(r_main, wb_we, wb_rd, wb_data);
    w_skid_snp = snoop_entry(r_skid, wb_we, wb_rd, wb_data);
  end

  // FSM state register; in_ready is registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != S_TWO);
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_in_xfer) w_next_state = S_ONE;
        S_ONE: begin
          if (w_out_xfer && !w_in_xfer)      w_next_state = S_EMPTY;
          else if (!w_out_xfer && w_in_xfer) w_next_state = S_TWO;
        end
        S_TWO:   if (w_out_xfer) w_next_state = S_ONE;
        default: w_next_state = S_EMPTY;
      endcase
    end
  end

  // FSM output logic: buffer load/hold controls.
  always_comb begin
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_hold_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_hold_skid      = 1'b0;
    if (!flush) begin
      case (r_state)
        S_EMPTY: w_load_main_in = w_in_xfer;
        S_ONE: begin
          if (w_out_xfer) begin
            w_load_main_in = w_in_xfer;
          end else begin
            w_hold_main = 1'b1;
            w_load_skid = w_in_xfer;
          end
        end
        S_TWO: begin
          if (w_out_xfer) begin
            w_load_main_skid = 1'b1;
          end else begin
            w_hold_main = 1'b1;
            w_hold_skid = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Entry storage: load from input or skid, otherwise snoop while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in)        r_main <= w_cap;
      else if (w_load_main_skid) r_main <= w_skid_snp;
      else if (w_hold_main)      r_main <= w_main_snp;

      if (w_load_skid)           r_skid <= w_cap;
      else if (w_hold_skid)      r_skid <= w_skid_snp;
    end
  end

  // Outputs come straight from flops; an empty stage presents a NOP.
  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != S_EMPTY);
  assign operand_a   = r_main.a;
  assign operand_b   = r_main.b;
  assign out_rd_addr = out_valid ? r_main.rd_addr : '0;
  assign out_rd_we   = out_valid && r_main.rd_we;
  assign out_illegal = out_valid && r_main.illegal;
  assign {alu_sel_pass2, alu_sel_pass1, alu_sel_sub, alu_sel_add, alu_sel_nop} =
         out_valid ? r_main.sel : SEL_NOP;

endmodule
